control_sequencer: RTL
======================

# control_sequencer

Microcoded control unit for the 8-bit single-bus CPU. It takes the instruction byte held by the instruction register and steps through fetch and execute T-states. Each cycle it drives the one-hot control strobes for PC, MAR, RAM, A/B registers, ALU, flags, output port and the instruction register itself, including that register's `load` and `data_out` strobes.

## Interface
Parameters: none. Opcode map fixed (below).
- `Clk`  in  1  system clock; all state updates on rising edge
- `Rst`  in  1  synchronous, active-low reset
- `INSTR`  in  8  instruction byte from the instruction register; opcode is [7:4], operand is driven on the bus by the IR
- `CARRY`  in  1  carry flag from the flags register
- `ZERO`  in  1  zero flag from the flags register
- `PC_OUT`, `PC_INC`, `PC_JUMP`  out  1 each  PC drives bus / increments / loads from bus
- `MAR_LOAD`  out  1  MAR loads from bus
- `RAM_OUT`, `RAM_LOAD`  out  1 each  RAM drives bus / writes from bus
- `IR_LOAD`, `IR_OUT`  out  1 each  IR loads from program EEPROM / IR drives operand nibble onto bus
- `A_OUT`, `A_LOAD`, `B_LOAD`  out  1 each  register strobes
- `ALU_OUT`, `ALU_SUB`, `FLAG_LOAD`  out  1 each  ALU drives bus / subtract select / flags capture
- `OUT_LOAD`  out  1  output port loads from bus
- `HALTED`  out  1  high while in HALT state
- `T_STATE`  out  3  current step: 0–4, or 7 for HALT

## Operation
- State register `step` holds T0–T4 or HALT. Opcode register `op` is 4 bits.
- Strobes are a combinational decode of `step`, `op`, `CARRY` and `ZERO`. All strobes are forced to 0 whenever `Rst`=0.
- Fetch, same for every instruction:
  - T0: `PC_OUT`, `MAR_LOAD`
  - T1: `IR_LOAD`, `PC_INC`. On the T1→T2 edge, `op` ← `INSTR[7:4]`.
- Execute, from T2. After the last listed step, the next state is T0. There are no idle T-states.
  - 0x0 NOP: T2 none
  - 0x1 LDA: T2 `IR_OUT`,`MAR_LOAD`; T3 `RAM_OUT`,`A_LOAD`
  - 0x2 ADD: T2 `IR_OUT`,`MAR_LOAD`; T3 `RAM_OUT`,`B_LOAD`; T4 `ALU_OUT`,`A_LOAD`,`FLAG_LOAD`
  - 0x3 SUB: as ADD, with `ALU_SUB` also high in T4
  - 0x4 STA: T2 `IR_OUT`,`MAR_LOAD`; T3 `A_OUT`,`RAM_LOAD`
  - 0x5 LDI: T2 `IR_OUT`,`A_LOAD`
  - 0x6 JMP: T2 `IR_OUT`,`PC_JUMP`
  - 0x7 JC: T2 `IR_OUT`,`PC_JUMP` only if `CARRY`=1; otherwise no strobes
  - 0x8 JZ: T2 as JC, conditioned on `ZERO`
  - 0xE OUT: T2 `A_OUT`,`OUT_LOAD`
  - 0xF HLT: T2 no strobes; next state is HALT
  - 0x9–0xD: treated as NOP
- HALT is absorbing. All strobes are 0, `HALTED`=1, `T_STATE`=7. Only reset exits HALT.
- Invariant: at most one bus driver (`PC_OUT`, `RAM_OUT`, `IR_OUT`, `A_OUT`, `ALU_OUT`) is asserted per cycle.

## Timing
- Reset: on a rising edge with `Rst`=0, `step`←T0, `op`←0 and `HALTED`←0. While `Rst`=0, every strobe output is 0 and `T_STATE`=0.
- After reset: on the first cycle with `Rst`=1, `PC_OUT`=`MAR_LOAD`=1 (T0).
- Instruction lengths in cycles:
  - 3: NOP, LDI, JMP, JC, JZ, OUT
  - 4: LDA, STA
  - 5: ADD, SUB
- Conditional jumps: `CARRY` and `ZERO` are sampled combinationally during T2. A flag change in any other step has no effect.
- `ALU_SUB` is asserted only in T4. Flags update at the end of T4 through `FLAG_LOAD`.
- `INSTR` is ignored except on the T1→T2 edge. Changes during execute do not alter the running instruction.
- Reset mid-instruction, any step including HALT: the next state is T0 and no partial strobes carry over.

## Test plan
- Reset: hold `Rst`=0 for 3 cycles → all strobes 0 and `T_STATE`=0. Release → T0 strobes in the first cycle, T1 `IR_LOAD`+`PC_INC` in the second.
- LDI: `INSTR`=0x55 → T2 `IR_OUT`+`A_LOAD`; next cycle is T0. Sequence length is 3 cycles.
- ADD/SUB: `INSTR`=0x2A → 5-cycle sequence exactly as listed, `FLAG_LOAD` only in T4. With 0x3A, `ALU_SUB`=1 only in T4.
- Conditional jump: JC 0x73 with `CARRY`=1 → T2 `PC_JUMP`+`IR_OUT`. Repeat with `CARRY`=0 → no strobes in T2, then T0. Same two checks for JZ 0x84 using `ZERO`.
- HLT: `INSTR`=0xF0 → after T2, `HALTED`=1 and `T_STATE`=7 with strobes 0 for 20 cycles. `Rst`=0 for one edge → T0 resumes.
- Mid-op reset and bus invariant: assert `Rst` during ADD T3 → next state T0, `op`=0. Across a random opcode stream, assert ≤1 bus driver every cycle.

Source files
------------

// File: rtl/control_sequencer.sv
// Microcoded control unit for the 8-bit single-bus CPU: steps fetch/execute
// T-states and decodes the one-hot control strobes for every bus participant.
module control_sequencer (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [7:0] INSTR,
    input  logic       CARRY,
    input  logic       ZERO,
    output logic       PC_OUT,
    output logic       PC_INC,
    output logic       PC_JUMP,
    output logic       MAR_LOAD,
    output logic       RAM_OUT,
    output logic       RAM_LOAD,
    output logic       IR_LOAD,
    output logic       IR_OUT,
    output logic       A_OUT,
    output logic       A_LOAD,
    output logic       B_LOAD,
    output logic       ALU_OUT,
    output logic       ALU_SUB,
    output logic       FLAG_LOAD,
    output logic       OUT_LOAD,
    output logic       HALTED,
    output logic [2:0] T_STATE
);

    typedef enum logic [2:0] {
        T0   = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        T4   = 3'd4,
        HALT = 3'd7
    } step_t;

    typedef struct packed {
        logic pc_out;
        logic pc_inc;
        logic pc_jump;
        logic mar_load;
        logic ram_out;
        logic ram_load;
        logic ir_load;
        logic ir_out;
        logic a_out;
        logic a_load;
        logic b_load;
        logic alu_out;
        logic alu_sub;
        logic flag_load;
        logic out_load;
    } ctrl_t;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    step_t      step;
    step_t      next_step;
    logic [3:0] op;
    ctrl_t      ctrl;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            step <= T0;
            op   <= 4'h0;
        end else begin
            step <= next_step;
            // The opcode is captured only as fetch completes; INSTR is don't-care otherwise.
            if (step == T1) begin
                op <= INSTR[7:4];
            end
        end
    end

    always_comb begin
        ctrl      = '0;
        next_step = T0;
        case (step)
            T0: begin
                ctrl.pc_out   = 1'b1;
                ctrl.mar_load = 1'b1;
                next_step     = T1;
            end
            T1: begin
                ctrl.ir_load = 1'b1;
                ctrl.pc_inc  = 1'b1;
                next_step    = T2;
            end
            T2: begin
                case (op)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ctrl.ir_out   = 1'b1;
                        ctrl.mar_load = 1'b1;
                        next_step     = T3;
                    end
                    OP_LDI: begin
                        ctrl.ir_out = 1'b1;
                        ctrl.a_load = 1'b1;
                    end
                    OP_JMP: begin
                        ctrl.ir_out  = 1'b1;
                        ctrl.pc_jump = 1'b1;
                    end
                    OP_JC: begin
                        ctrl.ir_out  = CARRY;
                        ctrl.pc_jump = CARRY;
                    end
                    OP_JZ: begin
                        ctrl.ir_out  = ZERO;
                        ctrl.pc_jump = ZERO;
                    end
                    OP_OUT: begin
                        ctrl.a_out    = 1'b1;
                        ctrl.out_load = 1'b1;
                    end
                    OP_HLT: next_step = HALT;
                    default: ;
                endcase
            end
            T3: begin
                case (op)
                    OP_LDA: begin
                        ctrl.ram_out = 1'b1;
                        ctrl.a_load  = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        ctrl.ram_out = 1'b1;
                        ctrl.b_load  = 1'b1;
                        next_step    = T4;
                    end
                    OP_STA: begin
                        ctrl.a_out    = 1'b1;
                        ctrl.ram_load = 1'b1;
                    end
                    default: ;
                endcase
            end
            T4: begin
                ctrl.alu_out   = 1'b1;
                ctrl.a_load    = 1'b1;
                ctrl.flag_load = 1'b1;
                ctrl.alu_sub   = (op == OP_SUB);
            end
            HALT: next_step = HALT;
            default: next_step = T0;
        endcase
    end

    // Reset low masks every output combinationally, independent of the stored step.
    assign {PC_OUT, PC_INC, PC_JUMP, MAR_LOAD, RAM_OUT, RAM_LOAD, IR_LOAD, IR_OUT,
            A_OUT, A_LOAD, B_LOAD, ALU_OUT, ALU_SUB, FLAG_LOAD, OUT_LOAD} = Rst ? ctrl : '0;
    assign HALTED  = Rst && (step == HALT);
    assign T_STATE = Rst ? 3'(step) : 3'd0;

endmodule
